onchip_mem_port_arbiter: RTL and testbench
==========================================

Name: onchip_mem_port_arbiter

Overview:
- Shares one port of the 64K x 32 dual-port on-chip RAM between two Avalon-MM masters: m0 is the sprite/DMA fetch engine and m1 is the game-logic bridge.
- Round-robin arbitration with a zero-bubble grant path.
- Registered read-valid tracking that matches the RAM's 1-cycle read latency (address registered, q unregistered).
- Sits between the masters and the RAM's s2 port inside the qsys top level.

Parameters:
- ADDR_W, 16, word address width of the RAM port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_BURST, 4, max consecutive accepts held by one master (used only with ONCHIP_ARB_BURST_EN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mN_address  in  ADDR_W  master N word address (N=0,1)
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_W  master N write data
- mN_waitrequest  out  1  master N stall; request accepted when low while read|write
- mN_readdata  out  DATA_W  read data, valid only with mN_readdatavalid
- mN_readdatavalid  out  1  one-cycle read-return strobe
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; constant 1
- mem_readdata  in  DATA_W  from RAM q

Behaviour:
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, the request is a write; no readdatavalid is returned.
- Grant (combinational from reqN and last_grant):
  - Only one master requesting: that master wins.
  - Both requesting: the master not equal to last_grant wins.
  - Neither requesting: no grant; mem_chipselect=0, mem_write=0.
- mN_waitrequest = reqN & ~grantN. A master that is not requesting sees waitrequest=0.
- The RAM port is muxed from the granted master. With no grant, mem_address, mem_byteenable and mem_writedata hold the m0 values and mem_chipselect=0.
- mem_write = granted & write of the winner; mem_chipselect = any grant.
- last_grant register updates to the winner on every accepted cycle and holds otherwise.
- Read return: an accepted read in cycle T sets rd_pend=1 and rd_owner=N at the T edge. In cycle T+1, mN_readdatavalid=1 for the owner only.
- mN_readdata = mem_readdata passthrough to both masters.
- Throughput: back-to-back reads 1 per cycle with no bubbles. Alternating masters are supported every cycle.
- Reset (async assert, sync release): last_grant=1 (m0 wins the first conflict), rd_pend=0, rd_owner=0, burst count=0.
  - All readdatavalid=0.
  - waitrequest follows the combinational rule; grants are legal immediately after release.
- Reset mid-read: a pending readdatavalid is dropped and never delivered.
- No write/read ordering hazard: the RAM port is single-issue and in order.

Optional Feature:
- Macro: ONCHIP_ARB_BURST_EN.
- Defined:
  - A saturating counter bcnt (width clog2(MAX_BURST)+1) counts consecutive accepts by the current winner.
  - While the winner keeps requesting and bcnt < MAX_BURST, it retains the grant even when the other master requests.
  - When bcnt == MAX_BURST, or the winner drops its request, the other master wins and bcnt restarts at 1.
  - bcnt resets to 0.
- Undefined: strict per-cycle round-robin as above; no counter logic is synthesised.

Test Plan:
- Reset release, m0 read addr 0x0010 alone, RAM preload 0xDEADBEEF -> m0_waitrequest=0 cycle T, m0_readdatavalid=1 with readdata 0xDEADBEEF at T+1, m1_readdatavalid=0.
- m0 and m1 both read continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each readdatavalid pulses the cycle after its grant; the loser's waitrequest=1.
- m1 writes 0x12345678 with byteenable 4'b0011 to 0x0200, then m0 reads 0x0200 -> m0 data low half 0x5678, upper bytes equal to prior contents.
- m0 read accepted, reset_n pulsed low for 1 cycle before the T+1 edge -> no readdatavalid; first post-reset conflict grants m0.
- m0 read+write both high to 0x0004 -> write performed, no readdatavalid.
- With ONCHIP_ARB_BURST_EN and MAX_BURST=4, both masters requesting 10 cycles -> grants m0 x4, m1 x4, m0 x2.

Source files
------------

// File: rtl/onchip_mem_port_arbiter.sv
// Two-master round-robin arbiter for one port of the 64K x 32 on-chip RAM.
// m0 = sprite/DMA fetch engine, m1 = game-logic bridge. The grant is decided
// combinationally, so an accepted request needs no extra cycle. Read-valid is
// registered to line up with the RAM's 1-cycle read latency.
// Optional build macro: ONCHIP_ARB_BURST_EN lets the current winner hold the
// port for up to MAX_BURST consecutive accepts.
module onchip_mem_port_arbiter #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   // master 0
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   // master 1
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   // RAM port
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   // A zero-length burst would make the hold rule meaningless.
   if (MAX_BURST < 1) begin : g_cfg_check
      $error("MAX_BURST must be at least 1");
   end

   logic w_req0;
   logic w_req1;
   logic w_gnt0;
   logic w_gnt1;
   logic w_any;
   logic w_acc_read;

   logic r_last_grant;   // 0 = m0 won last accept, 1 = m1
   logic r_rd_pend;
   logic r_rd_owner;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;
   assign w_any  = w_gnt0 | w_gnt1;

`ifdef ONCHIP_ARB_BURST_EN
   localparam int unsigned BcntW = $clog2(MAX_BURST) + 1;

   logic [BcntW-1:0] r_bcnt;
   logic [BcntW-1:0] w_bcnt_d;
   logic             w_last_req;
   logic             w_hold;

   // bcnt == 0 means no run in progress (after reset), so plain round-robin applies.
   assign w_last_req = r_last_grant ? w_req1 : w_req0;
   assign w_hold     = w_last_req && (r_bcnt != '0) && (r_bcnt < BcntW'(MAX_BURST));

   // Grant: lone requester wins; on conflict the previous winner keeps the port while its run is open.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_req0 && w_req1) begin
         w_gnt1 = w_hold ? r_last_grant : ~r_last_grant;
         w_gnt0 = ~w_gnt1;
      end else begin
         w_gnt0 = w_req0;
         w_gnt1 = w_req1;
      end
   end

   // Burst counter: extend the run for the same winner (saturating), restart at 1 on a change.
   always_comb begin
      w_bcnt_d = r_bcnt;
      if (w_any) begin
         if ((w_gnt1 == r_last_grant) && (r_bcnt != '0)) begin
            if (r_bcnt < BcntW'(MAX_BURST)) begin
               w_bcnt_d = r_bcnt + 1'b1;
            end
         end else begin
            w_bcnt_d = BcntW'(1);
         end
      end
   end

   // Burst counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bcnt <= '0;
      end else begin
         r_bcnt <= w_bcnt_d;
      end
   end
`else
   // Grant: lone requester wins; on conflict the master that did not win last time wins.
   always_comb begin
      w_gnt0 = w_req0 & (~w_req1 | r_last_grant);
      w_gnt1 = w_req1 & (~w_req0 | ~r_last_grant);
   end
`endif

   // Accepted read: a request with write also high is treated as a write only.
   always_comb begin
      w_acc_read = 1'b0;
      if (w_gnt1) begin
         w_acc_read = m1_read & ~m1_write;
      end else if (w_gnt0) begin
         w_acc_read = m0_read & ~m0_write;
      end
   end

   // Arbitration history and read-return tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= 1'b0;
      end else begin
         if (w_any) begin
            r_last_grant <= w_gnt1;
         end
         r_rd_pend <= w_acc_read;
         if (w_acc_read) begin
            r_rd_owner <= w_gnt1;
         end
      end
   end

   // RAM port mux; m0 fields are presented whenever m1 is not granted.
   always_comb begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = w_gnt0 & m0_write;
      if (w_gnt1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
         mem_write      = m1_write;
      end
      mem_chipselect = w_any;
      mem_clken      = 1'b1;
   end

   // Master-side handshake and read return.
   always_comb begin
      m0_waitrequest   = w_req0 & ~w_gnt0;
      m1_waitrequest   = w_req1 & ~w_gnt1;
      m0_readdatavalid = r_rd_pend & ~r_rd_owner;
      m1_readdatavalid = r_rd_pend & r_rd_owner;
      m0_readdata      = mem_readdata;
      m1_readdata      = mem_readdata;
   end

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Directed bench for onchip_mem_port_arbiter with a behavioural 1-cycle-latency RAM
// on the memory port. Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_onchip_mem_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic [15:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [15:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   int n_tests = 0;
   int n_fail  = 0;

   onchip_mem_port_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (32),
      .MAX_BURST (4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: registered address, unregistered q, byte-masked writes.
   logic [31:0] ram [0:65535];
   logic [15:0] ram_addr_q = 16'h0000;
   assign mem_readdata = ram[ram_addr_q];

   always @(posedge clk) begin : ram_model
      logic [31:0] w;
      if (mem_chipselect && mem_clken) begin
         ram_addr_q <= mem_address;
         if (mem_write) begin
            w = ram[mem_address];
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
            end
            ram[mem_address] <= w;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      m0_address = 16'h1234; m1_address = 16'h5678;
      m0_byteenable = 4'hF;  m1_byteenable = 4'hF;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      m0_writedata = 32'h0; m1_writedata = 32'h0;
      ram[16'h0010] = 32'hDEADBEEF;
      ram[16'h0200] = 32'hAABBCCDD;
      ram[16'h0004] = 32'h11111111;
      ram[16'h0030] = 32'h30303030;
      ram[16'h0031] = 32'h31313131;
      reset_n = 1'b0;

      // In reset, idle: no strobes, no grant, m0 fields on the RAM port.
      repeat (2) @(negedge clk);
      #1;
      check("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      check("rst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
      check("rst_wait0", {31'b0, m0_waitrequest}, 32'd0);
      check("rst_wait1", {31'b0, m1_waitrequest}, 32'd0);
      check("idle_cs", {31'b0, mem_chipselect}, 32'd0);
      check("idle_wr", {31'b0, mem_write}, 32'd0);
      check("idle_addr", {16'b0, mem_address}, 32'h1234);
      check("clken", {31'b0, mem_clken}, 32'd1);

      @(negedge clk);
      reset_n = 1'b1;

      // m0 lone read of 0x0010.
      @(negedge clk);
      m0_address = 16'h0010; m0_read = 1'b1;
      #1;
      check("rd_wait0", {31'b0, m0_waitrequest}, 32'd0);
      check("rd_cs", {31'b0, mem_chipselect}, 32'd1);
      check("rd_addr", {16'b0, mem_address}, 32'h0010);
      check("rd_wr", {31'b0, mem_write}, 32'd0);

      // Read returns; m1 issues a partial write to 0x0200.
      @(negedge clk);
      m0_read = 1'b0;
      m1_address = 16'h0200; m1_write = 1'b1; m1_byteenable = 4'b0011;
      m1_writedata = 32'h12345678;
      #1;
      check("rd_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
      check("rd_data", m0_readdata, 32'hDEADBEEF);
      check("rd_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
      check("wr_wait1", {31'b0, m1_waitrequest}, 32'd0);
      check("wr_memwr", {31'b0, mem_write}, 32'd1);
      check("wr_addr", {16'b0, mem_address}, 32'h0200);
      check("wr_be", {28'b0, mem_byteenable}, 32'h3);
      check("wr_data", mem_writedata, 32'h12345678);

      // m0 reads the written word back.
      @(negedge clk);
      m1_write = 1'b0;
      m0_address = 16'h0200; m0_read = 1'b1;
      #1;
      check("wr_no_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
      check("wr_no_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      check("rb_wait0", {31'b0, m0_waitrequest}, 32'd0);

      // Readback data; m0 then issues read+write together to 0x0004.
      @(negedge clk);
      m0_address = 16'h0004; m0_write = 1'b1; m0_writedata = 32'hCAFEF00D;
      m0_byteenable = 4'hF;
      #1;
      check("rb_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
      check("rb_data", m0_readdata, 32'hAABB5678);
      check("rw_memwr", {31'b0, mem_write}, 32'd1);
      check("rw_wait0", {31'b0, m0_waitrequest}, 32'd0);

      // Plain read of 0x0004; read+write must not have produced a strobe.
      @(negedge clk);
      m0_write = 1'b0;
      #1;
      check("rw_no_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      check("rw_rd_memwr", {31'b0, mem_write}, 32'd0);

      @(negedge clk);
      m0_read = 1'b0;
      #1;
      check("rw_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
      check("rw_data", m0_readdata, 32'hCAFEF00D);

      // Read accepted, then reset before the return edge: strobe must be dropped.
      @(negedge clk);
      m0_address = 16'h0010; m0_read = 1'b1;
      #1;
      check("rr_wait0", {31'b0, m0_waitrequest}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b0; m0_read = 1'b0;
      #1;
      check("rr_rdv0_in_rst", {31'b0, m0_readdatavalid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rr_rdv0_after", {31'b0, m0_readdatavalid}, 32'd0);
      check("rr_rdv1_after", {31'b0, m1_readdatavalid}, 32'd0);

`ifndef ONCHIP_ARB_BURST_EN
      // Both masters read continuously: strict alternation starting with m0.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         m0_address = 16'h0030; m0_read = 1'b1;
         m1_address = 16'h0031; m1_read = 1'b1;
         #1;
         check($sformatf("rr%0d_wait0", i), {31'b0, m0_waitrequest}, (i % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("rr%0d_wait1", i), {31'b0, m1_waitrequest}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr%0d_addr", i), {16'b0, mem_address},
               (i % 2 == 1) ? 32'h0031 : 32'h0030);
         if (i > 0) begin
            check($sformatf("rr%0d_rdv0", i), {31'b0, m0_readdatavalid},
                  (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_rdv1", i), {31'b0, m1_readdatavalid},
                  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_data", i), m0_readdata,
                  (i % 2 == 1) ? 32'h30303030 : 32'h31313131);
         end
      end
      @(negedge clk);
      m0_read = 1'b0; m1_read = 1'b0;
      #1;
      check("rr_last_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
      check("rr_last_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      check("rr_last_data", m1_readdata, 32'h31313131);
      @(negedge clk);
      #1;
      check("rr_quiet_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
`else
      // Both masters request for 10 cycles: m0 x4, m1 x4, m0 x2 (bit i = m1 granted).
      begin
         logic [9:0] exp_g;
         exp_g = 10'b0011110000;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m0_address = 16'h0030; m0_read = 1'b1;
            m1_address = 16'h0031; m1_read = 1'b1;
            #1;
            check($sformatf("bu%0d_wait0", i), {31'b0, m0_waitrequest}, {31'b0, exp_g[i]});
            check($sformatf("bu%0d_wait1", i), {31'b0, m1_waitrequest}, {31'b0, ~exp_g[i]});
            if (i > 0) begin
               check($sformatf("bu%0d_rdv1", i), {31'b0, m1_readdatavalid},
                     {31'b0, exp_g[i-1]});
            end
         end
         @(negedge clk);
         m0_read = 1'b0; m1_read = 1'b0;
         #1;
         check("bu_last_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
